mul_share_arbiter: RTL and testbench
====================================

# mul_share_arbiter

Round-robin scheduler that shares one iterative 64x64 multiplier core among N requesters. Each requester posts an operand pair with a valid/ready handshake. The block grants one requester at a time, sequences the core's start/ready protocol, and returns the 128-bit product with a tag on a held response channel. A watchdog aborts a job if the core stops responding. The block sits between the client ports and the multiplier's A/B/start/ready/P pins.

## Interface
- N, 4: number of requesters (2..16); IW = clog2(N).
- TIMEOUT, 64: maximum cycles from ISSUE entry to core completion before abort (must exceed the core latency of 35).
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-high.
- req_valid  in  N  per-requester request.
- req_ready  out  N  one-hot grant/accept; reset 0.
- req_a  in  N*64  operand A, slice i for requester i.
- req_b  in  N*64  operand B, slice i for requester i.
- rsp_valid  out  N  one-hot response valid for the owning requester; reset 0.
- rsp_ready  in  N  per-requester response accept.
- rsp_p  out  128  product; reset 0.
- rsp_id  out  IW  index of the owning requester; reset 0.
- rsp_err  out  1  response is a watchdog abort; reset 0.
- mul_a  out  64  to core A; reset 0.
- mul_b  out  64  to core B; reset 0.
- mul_start  out  1  to core start; reset 0.
- mul_ready  in  1  core idle flag.
- mul_p  in  128  core product; valid while mul_ready=1 after a job.

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP. Reset enters IDLE with ptr = N-1.
- IDLE
  - Winner is the first i with req_valid[i]=1, searching ptr+1, ptr+2, ... modulo N.
  - req_ready is one-hot on the winner and combinational from req_valid.
  - On handshake: capture req_a/req_b slices into mul_a/mul_b, set id = winner, go to ISSUE.
  - With no request: req_ready=0 and the state holds.
- ISSUE
  - If mul_ready=1: mul_start=1 for exactly this cycle, go to WAIT_ACK.
  - If mul_ready=0 (core still finishing a pre-reset job): mul_start=0 and the state holds.
- WAIT_ACK: when mul_ready=0, go to WAIT_DONE.
- WAIT_DONE: when mul_ready=1, capture mul_p into rsp_p, set rsp_err=0, go to RESP.
- RESP
  - rsp_valid[id]=1; rsp_p, rsp_id and rsp_err are held stable.
  - On rsp_ready[id]=1: ptr = id, clear rsp_valid, go to IDLE.
  - rsp_ready bits of other requesters are ignored.
- mul_a/mul_b hold the captured operands from ISSUE until the next accept. mul_start is 0 in every other state.
- Watchdog
  - Counter clears on entry to ISSUE and increments in ISSUE, WAIT_ACK and WAIT_DONE.
  - When it reaches TIMEOUT: go to RESP with rsp_err=1 and rsp_p=0.
- The product is passed through unmodified. The block performs no arithmetic on operands or result.

## Timing
- req_ready never asserts outside IDLE; at most one request is in flight.
- Core contract: start is sampled while ready=1; ready drops the next cycle; ready returns 35 cycles after the start cycle, with P valid.
- Cycle-level sequence, handshake in cycle t:
  - t+1: ISSUE, mul_start=1.
  - t+2: WAIT_ACK.
  - t+3..t+35: WAIT_DONE.
  - t+36: mul_ready=1, capture.
  - t+37: rsp_valid first high.
- Earliest next accept is the cycle after the rsp handshake (IDLE re-entry).
- rst mid-job: all outputs return to their reset values next cycle and the in-flight result is discarded. The core itself is not reset; ISSUE waits on mul_ready so a stale completion is never mistaken for a new one.
- A req_valid deasserted before grant is simply not served; there is no request queueing.

## Test plan
- Single request: rst, then req_valid[2]=1 with A=3, B=5 -> req_ready=0100 for one cycle, mul_start pulse at t+1, rsp_valid=0100 at t+37, rsp_p=15, rsp_id=2, rsp_err=0.
- Fairness: all four req_valid held high with distinct operands -> grants in order 0,1,2,3,0, and each rsp_id matches its operand product (e.g. A=2^63-1, B=2 -> 0xFFFFFFFFFFFFFFFE).
- Backpressure: hold rsp_ready low for 10 cycles -> rsp_valid, rsp_p and rsp_id stable; no new req_ready until 1 cycle after rsp_ready rises.
- Watchdog: core model keeps mul_ready low forever after start -> rsp_valid at TIMEOUT cycles after ISSUE entry, with rsp_err=1 and rsp_p=0.
- Reset mid-job: assert rst at t+10, then present req_valid[1] -> mul_start withheld until mul_ready=1 (old job finishes), and the response carries the new product only.
- Start hygiene: across all scenarios, mul_start is never high for two consecutive cycles and never high while mul_ready=0.

Source files
------------

// File: rtl/mul_share_arbiter_if.sv
// Bus bundle between N requesters, the shared-multiplier scheduler and the
// iterative 64x64 multiplier core. The scheduler side uses the slave modport;
// the requesters plus the core (or a bench standing in for them) use master.
interface mul_share_arbiter_if #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
);
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*64-1:0]   req_a;
    logic [N*64-1:0]   req_b;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready;
    logic [127:0]      rsp_p;
    logic [IW-1:0]     rsp_id;
    logic              rsp_err;
    logic [63:0]       mul_a;
    logic [63:0]       mul_b;
    logic              mul_start;
    logic              mul_ready;
    logic [127:0]      mul_p;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_ready, mul_p,
        output req_ready, rsp_valid, rsp_p, rsp_id, rsp_err, mul_a, mul_b, mul_start
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_ready, mul_p,
        input  req_ready, rsp_valid, rsp_p, rsp_id, rsp_err, mul_a, mul_b, mul_start
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin scheduler sharing one iterative 64x64 multiplier among N
// requesters. One job is in flight at a time; the product (or a watchdog
// abort) is returned on a held, tagged response channel.
module mul_share_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    mul_share_arbiter_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    localparam logic [IW-1:0] PTR_RESET = IW'(N - 1);
    localparam logic [WW-1:0] WDT_LAST  = WW'(TIMEOUT - 1);

    logic [2:0]    state_r;
    logic [2:0]    state_nxt_s;
    logic [IW-1:0] ptr_r;
    logic [IW-1:0] win_s;
    logic [IW-1:0] rsp_id_r;
    logic [N-1:0]  win_onehot_s;
    logic [N-1:0]  id_onehot_s;
    logic [N-1:0]  req_ready_s;
    logic [N-1:0]  rsp_valid_r;
    logic [WW-1:0] wdt_r;
    logic [63:0]   mul_a_r;
    logic [63:0]   mul_b_r;
    logic [63:0]   a_sel_s;
    logic [63:0]   b_sel_s;
    logic [127:0]  rsp_p_r;
    logic          rsp_err_r;
    logic          found_s;
    logic          accept_s;
    logic          start_s;
    logic          done_s;
    logic          abort_s;
    logic          rsp_hs_s;
    logic          busy_s;
    logic          wdt_exp_s;

    // Round-robin search: first valid requester after the last one served.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!found_s && bus.req_valid[(int'(ptr_r) + k) % N]) begin
                found_s = 1'b1;
                win_s   = IW'((int'(ptr_r) + k) % N);
            end else begin
                found_s = found_s;
            end
        end
        win_onehot_s        = '0;
        win_onehot_s[win_s] = found_s;
    end

    // Operand slices of the winner and one-hot tag of the job owner.
    always_comb begin
        a_sel_s               = bus.req_a[64*int'(win_s) +: 64];
        b_sel_s               = bus.req_b[64*int'(win_s) +: 64];
        id_onehot_s           = '0;
        id_onehot_s[rsp_id_r] = 1'b1;
    end

    // Next-state and per-cycle strobes; watchdog abort outranks everything
    // except a completion arriving in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        req_ready_s = '0;
        accept_s    = 1'b0;
        start_s     = 1'b0;
        done_s      = 1'b0;
        abort_s     = 1'b0;
        rsp_hs_s    = 1'b0;
        busy_s      = 1'b0;
        wdt_exp_s   = (wdt_r == WDT_LAST);
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    req_ready_s = win_onehot_s;
                    accept_s    = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                busy_s = 1'b1;
                if (wdt_exp_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_RESP;
                end else if (bus.mul_ready) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_WAIT_ACK;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT_ACK: begin
                busy_s = 1'b1;
                if (wdt_exp_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_RESP;
                end else if (!bus.mul_ready) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DONE: begin
                busy_s = 1'b1;
                if (bus.mul_ready) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_RESP;
                end else if (wdt_exp_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready[rsp_id_r]) begin
                    rsp_hs_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, captured operands, watchdog and held response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= PTR_RESET;
            rsp_id_r    <= '0;
            rsp_valid_r <= '0;
            rsp_p_r     <= '0;
            rsp_err_r   <= 1'b0;
            mul_a_r     <= '0;
            mul_b_r     <= '0;
            wdt_r       <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                mul_a_r  <= a_sel_s;
                mul_b_r  <= b_sel_s;
                rsp_id_r <= win_s;
                wdt_r    <= '0;
            end else if (busy_s) begin
                wdt_r <= wdt_r + WW'(1);
            end
            if (done_s) begin
                rsp_p_r     <= bus.mul_p;
                rsp_err_r   <= 1'b0;
                rsp_valid_r <= id_onehot_s;
            end else if (abort_s) begin
                rsp_p_r     <= '0;
                rsp_err_r   <= 1'b1;
                rsp_valid_r <= id_onehot_s;
            end else if (rsp_hs_s) begin
                rsp_valid_r <= '0;
                ptr_r       <= rsp_id_r;
            end
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_p     = rsp_p_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.mul_a     = mul_a_r;
    assign bus.mul_b     = mul_b_r;
    assign bus.mul_start = start_s;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: requester driver, multiplier core
// model, response-ready driver, and a monitor comparing against a
// round-robin/product reference model.
module tb_mul_share_arbiter;
    localparam int N   = 4;
    localparam int TMO = 64;
    localparam int IW  = $clog2(N);

    typedef struct {
        int          id;
        logic [63:0] a;
        logic [63:0] b;
    } req_t;

    typedef struct {
        int           id;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] p;
        logic         err;
        int           lat;
        int           gcyc;
        bit           seen;
        bit           late;
    } job_t;

    logic clk = 1'b0;
    logic rst;
    bit   hang;
    int   rr_mode;
    bit   end_req;
    bit   end_done;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   m_busy;
    int   m_ptr;
    req_t pend[$];
    job_t sb_q[$];

    mul_share_arbiter_if #(.N(N)) bus ();

    mul_share_arbiter #(.N(N), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [127:0] mul128(input logic [63:0] a, input logic [63:0] b);
        return {64'd0, a} * {64'd0, b};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 3))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'd0;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic chk(input string nm, input bit ok, input logic [127:0] act, input logic [127:0] exp);
        n_chk = n_chk + 1;
        if (!ok) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic post(input int id, input logic [63:0] a, input logic [63:0] b);
        req_t r;
        r.id = id;
        r.a  = a;
        r.b  = b;
        pend.push_back(r);
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (pend.size() == 0 && bus.req_valid == '0 && !m_busy && sb_q.size() == 0) break;
        end
    endtask

    // Requester side: present queued jobs, drop valid after each handshake.
    initial begin : req_driver
        logic [N-1:0] hs;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        forever begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready & {N{~rst}};
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) bus.req_valid[i] = 1'b0;
                if (!bus.req_valid[i]) begin
                    for (int j = 0; j < pend.size(); j++) begin
                        if (pend[j].id == i) begin
                            bus.req_a[i*64 +: 64] = pend[j].a;
                            bus.req_b[i*64 +: 64] = pend[j].b;
                            bus.req_valid[i]      = 1'b1;
                            pend.delete(j);
                            break;
                        end
                    end
                end
            end
        end
    end

    // Response-ready pattern: random, all low (backpressure) or all high.
    initial begin : rsp_driver
        bus.rsp_ready = '0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       bus.rsp_ready = N'($urandom());
                1:       bus.rsp_ready = '0;
                default: bus.rsp_ready = '1;
            endcase
        end
    end

    // Multiplier core: start taken while ready, ready back 35 cycles after start.
    initial begin : core_model
        logic         st;
        logic [63:0]  ca;
        logic [63:0]  cb;
        logic [127:0] prod;
        int           cnt;
        bus.mul_ready = 1'b1;
        bus.mul_p     = '0;
        prod          = '0;
        cnt           = 0;
        forever begin
            @(negedge clk);
            st = (bus.mul_start === 1'b1);
            ca = bus.mul_a;
            cb = bus.mul_b;
            @(posedge clk);
            #1;
            if (bus.mul_ready) begin
                if (st) begin
                    bus.mul_ready = 1'b0;
                    cnt           = 34;
                    prod          = mul128(ca, cb);
                    bus.mul_p     = {$urandom(), $urandom(), $urandom(), $urandom()};
                end
            end else if (!hang && cnt == 1) begin
                bus.mul_ready = 1'b1;
                bus.mul_p     = prod;
            end else begin
                cnt       = cnt - 1;
                bus.mul_p = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
    end

    // Monitor: reference model for grants, start pulses and responses.
    initial begin : monitor
        job_t         j;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_v;
        int           pick;
        bit           rst_seen;
        bit           prev_start;
        bit           ok;
        m_busy     = 1'b0;
        m_ptr      = N - 1;
        rst_seen   = 1'b0;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (rst) begin
                sb_q.delete();
                m_busy     = 1'b0;
                m_ptr      = N - 1;
                rst_seen   = 1'b1;
                prev_start = 1'b0;
            end else begin
                if (rst_seen) begin
                    ok = (bus.rsp_valid === '0) && (bus.rsp_p === 128'd0) && (bus.rsp_id === '0) &&
                         (bus.rsp_err === 1'b0) && (bus.mul_a === 64'd0) && (bus.mul_b === 64'd0) &&
                         (bus.mul_start === 1'b0);
                    chk("reset_vals", ok, 128'({bus.rsp_valid, bus.rsp_err, bus.mul_start, bus.rsp_id}), 128'd0);
                    rst_seen = 1'b0;
                end
                exp_rdy = '0;
                pick    = -1;
                if (!m_busy) pick = rr_pick(bus.req_valid, m_ptr);
                if (pick >= 0) exp_rdy[pick] = 1'b1;
                if (bus.req_valid != '0 || bus.req_ready != '0)
                    chk("grant", bus.req_ready === exp_rdy, 128'(bus.req_ready), 128'(exp_rdy));
                if (pick >= 0) begin
                    j.id   = pick;
                    j.a    = bus.req_a[pick*64 +: 64];
                    j.b    = bus.req_b[pick*64 +: 64];
                    j.err  = hang;
                    j.p    = hang ? 128'd0 : mul128(j.a, j.b);
                    j.lat  = hang ? (1 + TMO) : ((bus.mul_ready === 1'b1) ? 37 : 0);
                    j.gcyc = cyc;
                    j.seen = 1'b0;
                    j.late = 1'b0;
                    sb_q.push_back(j);
                    m_busy = 1'b1;
                end
                if (bus.mul_start === 1'b1) begin
                    ok = (bus.mul_ready === 1'b1) && !prev_start;
                    if (sb_q.size() > 0)
                        ok = ok && (bus.mul_a === sb_q[0].a) && (bus.mul_b === sb_q[0].b);
                    chk("start", ok, 128'({bus.mul_ready, prev_start}), 128'(2'b10));
                end
                if (sb_q.size() > 0 && sb_q[0].lat > 0 && cyc == sb_q[0].gcyc + 1)
                    chk("start_time", bus.mul_start === 1'b1, 128'(bus.mul_start), 128'd1);
                prev_start = (bus.mul_start === 1'b1);
                if (bus.rsp_valid !== '0) begin
                    if (sb_q.size() == 0) begin
                        chk("rsp_unexpected", 1'b0, 128'(bus.rsp_valid), 128'd0);
                    end else begin
                        j            = sb_q[0];
                        exp_v        = '0;
                        exp_v[j.id]  = 1'b1;
                        chk("rsp_valid", bus.rsp_valid === exp_v, 128'(bus.rsp_valid), 128'(exp_v));
                        chk("rsp_id", bus.rsp_id === IW'(j.id), 128'(bus.rsp_id), 128'(j.id));
                        chk("rsp_p", bus.rsp_p === j.p, bus.rsp_p, j.p);
                        chk("rsp_err", bus.rsp_err === j.err, 128'(bus.rsp_err), 128'(j.err));
                        if (!j.seen && j.lat > 0)
                            chk("rsp_latency", (cyc - j.gcyc) == j.lat, 128'(cyc - j.gcyc), 128'(j.lat));
                        j.seen  = 1'b1;
                        sb_q[0] = j;
                        if (bus.rsp_ready[j.id] === 1'b1) begin
                            void'(sb_q.pop_front());
                            m_ptr  = j.id;
                            m_busy = 1'b0;
                        end
                    end
                end else if (sb_q.size() > 0 && !sb_q[0].late && (cyc - sb_q[0].gcyc) > 2 * TMO + 80) begin
                    chk("rsp_overdue", 1'b0, 128'(cyc - sb_q[0].gcyc), 128'(sb_q[0].lat));
                    j       = sb_q[0];
                    j.late  = 1'b1;
                    sb_q[0] = j;
                end
                if (end_req && !end_done) begin
                    chk("drained", sb_q.size() == 0 && pend.size() == 0, 128'(sb_q.size()), 128'd0);
                    end_done = 1'b1;
                end
            end
        end
    end

    // Scenario sequence.
    initial begin : scenario
        rst      = 1'b1;
        hang     = 1'b0;
        rr_mode  = 2;
        end_req  = 1'b0;
        end_done = 1'b0;
        step(3);
        rst = 1'b0;

        // Single request from requester 2.
        post(2, 64'd3, 64'd5);
        wait_idle(200);

        // Fairness from a fresh pointer: grants 0,1,2,3,0.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        post(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd2);
        post(1, 64'd1000, 64'd1000);
        post(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        post(3, 64'h0123_4567_89AB_CDEF, 64'd16);
        post(0, 64'd0, 64'hDEAD_BEEF_0000_0001);
        wait_idle(600);

        // Backpressure with a competing request queued behind it.
        rr_mode = 1;
        post(1, rand64(), rand64());
        for (int c = 0; c < 100 && bus.rsp_valid === '0; c++) step(1);
        post(3, rand64(), rand64());
        step(10);
        rr_mode = 2;
        wait_idle(300);

        // Random traffic with random response acceptance.
        rr_mode = 0;
        for (int k = 0; k < 12; k++) begin
            post($urandom_range(0, N - 1), rand64(), rand64());
            step($urandom_range(0, 30));
        end
        wait_idle(3000);

        // Reset ten cycles after a handshake, then a new job on requester 1.
        rr_mode = 2;
        post(0, rand64(), rand64());
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.req_ready[0] === 1'b1) break;
        end
        step(10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        post(1, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        wait_idle(400);

        // Watchdog: core never returns ready after the start.
        hang = 1'b1;
        post(3, rand64(), rand64());
        wait_idle(400);

        end_req = 1'b1;
        for (int c = 0; c < 10 && !end_done; c++) step(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
